// File: rtl/crc32_dec.sv
// Receive-side CRC checker: recomputes the beat CRC from a fixed coefficient
// table, registers payload/error/syndrome behind a skid-free ready/valid stage.
module crc32_dec #(
    parameter int DATA_WIDTH = 512,
    parameter int CRC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [CRC_WIDTH-1:0]  checksum_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  error_o,
    output logic [CRC_WIDTH-1:0]  syndrome_o,
    input  logic                  clear_i,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic                  err_sticky_o,
    output logic [CNT_WIDTH-1:0]  first_err_idx_o,
    output logic [CNT_WIDTH-1:0]  beat_cnt_o
);

    localparam logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(32'hD5828281);

    typedef logic [DATA_WIDTH-1:0][CRC_WIDTH-1:0] cols_t;

    // Column j is the CRC of a beat with only bit j set; data bit 0 is the
    // last bit shifted into the MSB-first LFSR, so column 0 is the polynomial.
    function automatic cols_t gen_cols();
        cols_t                c;
        logic [CRC_WIDTH-1:0] s;
        c = '0;
        s = POLY;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            c[j] = s;
            s    = {s[CRC_WIDTH-2:0], 1'b0} ^ (s[CRC_WIDTH-1] ? POLY : '0);
        end
        return c;
    endfunction

    localparam cols_t COLS = gen_cols();

    logic [CRC_WIDTH-1:0][DATA_WIDTH-1:0] coeff;

    for (genvar i = 0; i < CRC_WIDTH; i++) begin : g_row
        for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_bit
            assign coeff[i][j] = COLS[j][i];
        end
    end

    logic [CRC_WIDTH-1:0] crc;
    logic [CRC_WIDTH-1:0] syn;
    logic                 err;

    always_comb begin
        crc = '0;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            crc[i] = ^(data_i & coeff[i]);
        end
        syn = crc ^ checksum_i;
        err = |syn;
    end

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  error_q, error_d;
    logic [CRC_WIDTH-1:0]  syndrome_q, syndrome_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                  err_sticky_q, err_sticky_d;
    logic [CNT_WIDTH-1:0]  first_err_idx_q, first_err_idx_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  accept;
    logic                  consume;

    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;
    assign consume = valid_q && ready_i;

    always_comb begin
        valid_d         = valid_q;
        data_d          = data_q;
        error_d         = error_q;
        syndrome_d      = syndrome_q;
        err_cnt_d       = err_cnt_q;
        err_sticky_d    = err_sticky_q;
        first_err_idx_d = first_err_idx_q;
        beat_cnt_d      = beat_cnt_q;

        if (accept) begin
            valid_d    = 1'b1;
            data_d     = data_i;
            error_d    = err;
            syndrome_d = syn;
        end else if (consume) begin
            valid_d = 1'b0;
        end

        // A clear in the same cycle as an accept drops that beat from the stats.
        if (clear_i) begin
            err_cnt_d       = '0;
            err_sticky_d    = 1'b0;
            first_err_idx_d = '0;
            beat_cnt_d      = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (err) begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                if (!err_sticky_q) begin
                    first_err_idx_d = beat_cnt_q;
                    err_sticky_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= 1'b0;
            data_q          <= '0;
            error_q         <= 1'b0;
            syndrome_q      <= '0;
            err_cnt_q       <= '0;
            err_sticky_q    <= 1'b0;
            first_err_idx_q <= '0;
            beat_cnt_q      <= '0;
        end else begin
            valid_q         <= valid_d;
            data_q          <= data_d;
            error_q         <= error_d;
            syndrome_q      <= syndrome_d;
            err_cnt_q       <= err_cnt_d;
            err_sticky_q    <= err_sticky_d;
            first_err_idx_q <= first_err_idx_d;
            beat_cnt_q      <= beat_cnt_d;
        end
    end

    assign valid_o         = valid_q;
    assign data_o          = data_q;
    assign error_o         = error_q;
    assign syndrome_o      = syndrome_q;
    assign err_cnt_o       = err_cnt_q;
    assign err_sticky_o    = err_sticky_q;
    assign first_err_idx_o = first_err_idx_q;
    assign beat_cnt_o      = beat_cnt_q;

endmodule

// File: tb/tb_crc32_dec.sv
// Directed bench for crc32_dec: hand vectors, reference-LFSR loopback,
// backpressure ordering, clear collision, counter saturation and reset.
module tb_crc32_dec;

    localparam int DW  = 512;
    localparam int CW  = 32;
    localparam int NW  = 16;
    localparam int NW2 = 4;
    localparam logic [31:0] POLY = 32'hD5828281;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, valid_i, ready_o, valid_o, ready_i, error_o, clear_i, err_sticky_o;
    logic [DW-1:0] data_i, data_o;
    logic [CW-1:0] checksum_i, syndrome_o;
    logic [NW-1:0] err_cnt_o, first_err_idx_o, beat_cnt_o;

    logic           rst2, v2, rdy_o2, vo2, r2, err_o2, clr2, sticky2;
    logic [DW-1:0]  d2, do2;
    logic [CW-1:0]  c2, syn2;
    logic [NW2-1:0] ecnt2, fidx2, bcnt2;

    crc32_dec #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .checksum_i(checksum_i), .valid_o(valid_o),
        .ready_i(ready_i), .data_o(data_o), .error_o(error_o),
        .syndrome_o(syndrome_o), .clear_i(clear_i), .err_cnt_o(err_cnt_o),
        .err_sticky_o(err_sticky_o), .first_err_idx_o(first_err_idx_o),
        .beat_cnt_o(beat_cnt_o)
    );

    crc32_dec #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .CNT_WIDTH(NW2)) dut2 (
        .clk(clk), .rst(rst2), .valid_i(v2), .ready_o(rdy_o2),
        .data_i(d2), .checksum_i(c2), .valid_o(vo2),
        .ready_i(r2), .data_o(do2), .error_o(err_o2),
        .syndrome_o(syn2), .clear_i(clr2), .err_cnt_o(ecnt2),
        .err_sticky_o(sticky2), .first_err_idx_o(fidx2),
        .beat_cnt_o(bcnt2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Serial MSB-first LFSR, zero init: data bit DW-1 enters first, bit 0 last.
    function automatic logic [31:0] crc_ref(input logic [DW-1:0] d);
        logic [31:0] s;
        logic        fb;
        s = '0;
        for (int k = DW - 1; k >= 0; k--) begin
            fb = s[31] ^ d[k];
            s  = {s[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return s;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [DW-1:0] bpd(input int k);
        return DW'(32'hAB00 + k);
    endfunction

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        logic [CW-1:0] s;
    } exp_t;

    exp_t q[$];
    bit   mon_en = 1'b0;
    int   n_in = 0, n_out = 0, nerr_seen = 0, first_err_out = -1;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (valid_o && ready_i) begin
                exp_t e;
                chk("sb_nonempty", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sb_data", data_o, e.d);
                    chk("sb_err", error_o, e.e);
                    chk("sb_syn", syndrome_o, e.s);
                end
                if (error_o) begin
                    if (nerr_seen == 0) first_err_out = n_out;
                    nerr_seen++;
                end
                n_out++;
            end
            if (valid_i && ready_o) begin
                exp_t e;
                e.d = data_i;
                e.s = crc_ref(data_i) ^ checksum_i;
                e.e = |e.s;
                q.push_back(e);
                n_in++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [CW-1:0] c);
        valid_i    = 1'b1;
        data_i     = d;
        checksum_i = c;
        step();
        valid_i = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        int            b, k;

        rst = 1'b1; valid_i = 1'b0; data_i = '0; checksum_i = '0; ready_i = 1'b1; clear_i = 1'b0;
        rst2 = 1'b1; v2 = 1'b0; d2 = '0; c2 = '0; r2 = 1'b1; clr2 = 1'b0;
        repeat (2) step();
        rst = 1'b0; rst2 = 1'b0;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_syn", syndrome_o, 0);
        chk("rst_stats", {err_cnt_o, err_sticky_o, first_err_idx_o, beat_cnt_o}, 0);

        beat('0, 32'h0);
        chk("zero_valid", valid_o, 1);
        chk("zero_err", error_o, 0);
        chk("zero_syn", syndrome_o, 32'h0);
        chk("zero_beats", beat_cnt_o, 1);

        beat(DW'(1), 32'hD5828281);
        chk("bit0_err", error_o, 0);
        chk("bit0_data", data_o, 1);
        chk("bit0_beats", beat_cnt_o, 2);

        beat(DW'(2), 32'h7E878783);
        chk("bit1_err", error_o, 0);
        beat(DW'(3), 32'hAB050502);
        chk("bit01_err", error_o, 0);
        chk("bit01_data", data_o, 3);

        beat(DW'(1), 32'hD5828280);
        chk("bad1_err", error_o, 1);
        chk("bad1_syn", syndrome_o, 32'h1);
        chk("bad1_cnt", err_cnt_o, 1);
        chk("bad1_sticky", err_sticky_o, 1);
        chk("bad1_idx", first_err_idx_o, 4);
        chk("bad1_beats", beat_cnt_o, 5);

        beat(DW'(2), 32'h0);
        chk("bad2_syn", syndrome_o, 32'h7E878783);
        chk("bad2_cnt", err_cnt_o, 2);
        chk("bad2_idx", first_err_idx_o, 4);

        step();
        chk("drain_valid", valid_o, 0);

        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clr_stats", {err_cnt_o, err_sticky_o, first_err_idx_o, beat_cnt_o}, 0);

        // Loopback with two corrupted payloads.
        mon_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            d = rand_beat();
            c = crc_ref(d);
            if (i == 100 || i == 700) begin
                b    = $urandom_range(DW - 1, 0);
                d[b] = ~d[b];
            end
            valid_i = 1'b1; data_i = d; checksum_i = c;
            step();
        end
        valid_i = 1'b0;
        repeat (3) step();
        chk("lb_in", n_in, 1000);
        chk("lb_out", n_out, 1000);
        chk("lb_nerr", nerr_seen, 2);
        chk("lb_first_out", first_err_out, 100);
        chk("lb_cnt", err_cnt_o, 2);
        chk("lb_idx", first_err_idx_o, 100);
        chk("lb_beats", beat_cnt_o, 1000);

        // Backpressure: 5 stall cycles with valid_i held high.
        n_in = 0; n_out = 0;
        k = 0;
        valid_i = 1'b1;
        for (int cyc = 0; cyc < 40 && k < 12; cyc++) begin
            ready_i    = (cyc < 2 || cyc >= 7);
            data_i     = bpd(k);
            checksum_i = crc_ref(data_i);
            #1;
            if (cyc >= 2) chk("bp_vo", valid_o, 1);
            if (cyc >= 2 && cyc < 7) begin
                chk("bp_rdy", ready_o, 0);
                chk("bp_hold", data_o, bpd(1));
            end
            if (ready_o) k++;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) step();
        chk("bp_done", k, 12);
        chk("bp_in", n_in, 12);
        chk("bp_out", n_out, 12);
        chk("bp_q", q.size(), 0);

        // Clear collides with an accepted failing beat.
        valid_i = 1'b1; data_i = DW'(1); checksum_i = 32'h0; clear_i = 1'b1;
        step();
        valid_i = 1'b0; clear_i = 1'b0;
        chk("cc_cnt", err_cnt_o, 0);
        chk("cc_sticky", err_sticky_o, 0);
        chk("cc_beats", beat_cnt_o, 0);
        chk("cc_idx", first_err_idx_o, 0);
        chk("cc_valid", valid_o, 1);
        chk("cc_err", error_o, 1);
        chk("cc_syn", syndrome_o, 32'hD5828281);
        step();
        mon_en = 1'b0;

        // Narrow counters: saturation, wrap, then reset mid-stall.
        v2 = 1'b1; d2 = DW'(1); c2 = 32'h0; r2 = 1'b1;
        repeat (20) step();
        v2 = 1'b0;
        chk("sat_cnt", ecnt2, 15);
        chk("sat_beats", bcnt2, 4);
        chk("sat_sticky", sticky2, 1);
        chk("sat_idx", fidx2, 0);
        v2 = 1'b1; d2 = DW'(2); r2 = 1'b0;
        step();
        chk("stall_vo", vo2, 1);
        chk("stall_rdy", rdy_o2, 0);
        chk("stall_data", do2, 1);
        rst2 = 1'b1;
        step();
        rst2 = 1'b0; v2 = 1'b0;
        #1;
        chk("rst2_valid", vo2, 0);
        chk("rst2_data", do2, 0);
        chk("rst2_err", err_o2, 0);
        chk("rst2_syn", syn2, 0);
        chk("rst2_stats", {ecnt2, sticky2, fidx2, bcnt2}, 0);
        chk("rst2_rdy", rdy_o2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc32_dec.md
Name: crc32_dec

Overview:
Receive-side CRC-32 checker paired with CRC32_ENC. It accepts a DATA_WIDTH payload beat together with its transmitted 32-bit checksum and recomputes the CRC using the same coefficient table as the encoder. A registered, back-pressurable output stage presents the payload with a per-beat error flag and the syndrome. Error statistics (saturating count, sticky flag, first-failing beat index) are kept for status readout.

Parameters:
- DATA_WIDTH, 512, payload bits per beat.
- CRC_WIDTH, 32, checksum bits.
- CNT_WIDTH, 16, width of the error counter and the beat counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_i  in  1  input beat valid.
- ready_o  out  1  decoder can accept a beat.
- data_i  in  DATA_WIDTH  received payload.
- checksum_i  in  CRC_WIDTH  received checksum.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts the output beat.
- data_o  out  DATA_WIDTH  registered payload.
- error_o  out  1  1 = checksum mismatch for the beat on data_o.
- syndrome_o  out  CRC_WIDTH  computed CRC XOR checksum_i for the beat on data_o.
- clear_i  in  1  clears the error statistics.
- err_cnt_o  out  CNT_WIDTH  count of failing beats; saturates at all-ones.
- err_sticky_o  out  1  set on the first failing beat; held until cleared.
- first_err_idx_o  out  CNT_WIDTH  beat index of the first failing beat since the last clear.
- beat_cnt_o  out  CNT_WIDTH  number of accepted beats since the last clear; wraps.

Behaviour:
- CRC computation:
  - crc[i] = XOR-reduce(data_i AND COEFF[i]) for each i.
  - COEFF is bit-identical to the CRC32_ENC table, taken from the shared table source.
  - syndrome = crc XOR checksum_i; error = |syndrome.
  - All of this is combinational on the input side.
- Handshake:
  - A beat is accepted when valid_i && ready_o.
  - An output beat is consumed when valid_o && ready_i.
  - ready_o = !valid_o || ready_i. This is combinational from ready_i and there is no other input-to-output combinational path.
- Output register:
  - On accept, data_o, error_o and syndrome_o load on the next edge and valid_o is set to 1.
  - On consume without an accept, valid_o clears to 0.
  - If consume and accept happen in the same cycle, the new beat loads and valid_o stays 1.
- Stall: while valid_o=1 and ready_i=0, data_o, error_o and syndrome_o hold stable.
- Latency: 1 cycle from accept to valid_o. Full throughput of 1 beat/cycle when ready_i=1.
- Statistics:
  - Statistics update at accept time, not consume time.
  - beat_cnt increments on every accept and wraps from all-ones to 0.
  - On an accepted failing beat:
    - err_cnt increments, saturating at 2^CNT_WIDTH-1.
    - If err_sticky=0, first_err_idx loads the pre-increment beat_cnt value and err_sticky becomes 1.
- Clear:
  - clear_i zeroes err_cnt, err_sticky, first_err_idx and beat_cnt on the next edge.
  - If an accept occurs in the same cycle as clear_i, clear wins: that beat is not counted, but it still passes to the output normally.
- Reset (rst=1 at an edge):
  - valid_o=0, error_o=0, syndrome_o=0, data_o=0.
  - err_cnt_o=0, err_sticky_o=0, first_err_idx_o=0, beat_cnt_o=0.
  - ready_o=1 in the cycle after reset.
  - Reset mid-stall discards the held beat without handshake.
- No state machine beyond the output-valid bit. X on data_i is tolerated only when valid_i=0.

Test Plan:
- All-zero beat:
  - Stimulus: valid_i=1, data_i=0, checksum_i=0, ready_i=1.
  - Response: next cycle valid_o=1, error_o=0, syndrome_o=0x00000000, beat_cnt_o=1.
- Single-bit beat:
  - Stimulus: data_i=1, checksum_i=0xD5828281 (the encoder's value).
  - Response: error_o=0.
  - Then: same beat with checksum_i=0xD5828280.
  - Response: error_o=1, syndrome_o=0x00000001, err_cnt_o=1, err_sticky_o=1, first_err_idx_o=1.
- Random loopback:
  - Stimulus: 1000 random beats driven through CRC32_ENC into crc32_dec, with random single-bit payload flips on beats 100 and 700.
  - Response: error_o=1 exactly on those two beats; err_cnt_o=2; first_err_idx_o=100.
- Backpressure:
  - Stimulus: ready_i=0 for 5 cycles with valid_i=1 continuously.
  - Response: ready_o=0 during the stall, data_o stable, no beats lost or duplicated.
  - Then: on release, beats emerge in order, 1 per cycle.
- Clear collision:
  - Stimulus: clear_i=1 in the same cycle as an accepted failing beat.
  - Response: next cycle err_cnt_o=0, err_sticky_o=0, beat_cnt_o=0, but that beat still appears on the output with error_o=1.
- Saturation and reset:
  - Stimulus: CNT_WIDTH=4 with 20 failing beats.
  - Response: err_cnt_o=15 and beat_cnt_o=4 (wrapped).
  - Then: assert rst while valid_o=1 and ready_i=0.
  - Response: next cycle all outputs are at their reset values.
